acc_int3: RTL and testbench
===========================

ACC_INT3 -- requirements
Module: acc_int3

Interface
REQ-001 Parameter WIDTH, default 3: width of each incoming product word, equal to the multiplier stage output width.
REQ-002 Parameter ACC_WIDTH, default 8: accumulator and result width; ACC_WIDTH >= WIDTH.
REQ-003 Parameter CNT_WIDTH, default 4: width of the vector-length field.
REQ-004 Clock and reset: one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 start  input  1  begin a new accumulation; sampled only in IDLE.
REQ-008 len  input  CNT_WIDTH  number of products to accumulate; sampled with start.
REQ-009 P  input  WIDTH  product word from the upstream multiplier stage (lower WIDTH bits).
REQ-010 in_valid  input  1  P is valid this cycle.
REQ-011 in_ready  output  1  block accepts P this cycle.
REQ-012 sum  output  ACC_WIDTH  accumulated result.
REQ-013 ovf  output  1  sticky flag: an accumulation carried out of ACC_WIDTH bits.
REQ-014 out_valid  output  1  sum and ovf are final.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 busy  output  1  high in ACC or DONE.

Function
REQ-017 FSM states: IDLE, ACC, DONE.
REQ-018 In IDLE, start=1 and len!=0 -> ACC next cycle; accumulator cleared to 0, ovf cleared, remaining count loaded with len.
REQ-019 In IDLE, start=1 and len==0 -> DONE next cycle, with sum=0 and ovf=0.
REQ-020 start is ignored in ACC and DONE.
REQ-021 in_ready = 1 only in ACC; it is combinational from state only and never depends on in_valid.
REQ-022 Input handshake: in_valid & in_ready in a cycle -> acc <= (acc + zero-extended P) mod 2^ACC_WIDTH; ovf |= carry-out; remaining decrements by 1.
REQ-023 Cycles in ACC with in_valid=0 leave acc, ovf and remaining unchanged.
REQ-024 A handshake while remaining==1 -> DONE next cycle; out_valid is asserted in the cycle after the final accepted P (latency 1).
REQ-025 In DONE: out_valid=1 and sum/ovf are held stable while out_ready=0.
REQ-026 In DONE, out_ready=1 -> IDLE next cycle; the result is consumed in that cycle.
REQ-027 sum and ovf keep their last values in IDLE until the next accepted start clears them.
REQ-028 Maximum throughput is one product per cycle; back-to-back handshakes need no bubbles.

Reset
REQ-029 When rst_n=0 at a clock edge, the FSM goes to IDLE, and acc, remaining and ovf go to 0.
REQ-030 Reset values: in_ready=0, out_valid=0, busy=0, sum=0, ovf=0.
REQ-031 Reset asserted mid-ACC or in DONE aborts the operation; no result is produced and the partial sum is discarded.

Structure
REQ-032 A shared package acc_int3_pkg holds the state enum (IDLE/ACC/DONE) and the default width constants.
REQ-033 The ACC_WIDTH addition is instantiated as the team's adder_nbit sub-module (carry-out drives ovf); the FSM and counters are local RTL.

Verification
REQ-034 len=3, P=5,7,2 back-to-back, out_ready=1 -> out_valid in the cycle after the 3rd handshake; sum=14, ovf=0; then IDLE.
REQ-035 ACC_WIDTH=4, len=3, P=7,7,7 -> sum=5 (21 mod 16), ovf=1.
REQ-036 len=2, in_valid toggling 1,0,0,1 with P=3 then 4 -> only 2 handshakes counted; sum=7.
REQ-037 len=1, P=6, out_ready held 0 for 5 cycles -> out_valid=1 and sum=6 stable throughout; IDLE the cycle after out_ready=1.
REQ-038 start with len=0 -> DONE next cycle, sum=0, out_valid=1; start pulsed during ACC has no effect.
REQ-039 len=4, rst_n=0 after 2 handshakes -> next cycle IDLE, sum=0, out_valid=0; a new start with len=1, P=3 gives sum=3.

Source files
------------

// File: rtl/acc_int3_pkg.sv
// Shared definitions for the acc_int3 product accumulator: FSM state encoding
// and default widths used by the interface and the datapath.
`timescale 1ns/1ps
package acc_int3_pkg;

   localparam int DEF_WIDTH     = 3;
   localparam int DEF_ACC_WIDTH = 8;
   localparam int DEF_CNT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/acc_int3_if.sv
// Handshake bundle between a product source / result consumer and acc_int3.
// The master side drives requests and products; the slave side is the accumulator.
`timescale 1ns/1ps
interface acc_int3_if
   import acc_int3_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
);

   logic                 start;
   logic [CNT_WIDTH-1:0] len;
   logic [WIDTH-1:0]     P;
   logic                 in_valid;
   logic                 in_ready;
   logic [ACC_WIDTH-1:0] sum;
   logic                 ovf;
   logic                 out_valid;
   logic                 out_ready;
   logic                 busy;

   modport master (
      output start, len, P, in_valid, out_ready,
      input  in_ready, sum, ovf, out_valid, busy
   );

   modport slave (
      input  start, len, P, in_valid, out_ready,
      output in_ready, sum, ovf, out_valid, busy
   );

endinterface

// File: rtl/acc_int3_adder_nbit.sv
// Plain N-bit unsigned adder with carry-out; shared building block for the
// accumulator datapath.
`timescale 1ns/1ps
module adder_nbit #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] s,
   output logic         cout
);

   assign {cout, s} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/acc_int3.sv
// Length-counted accumulator of unsigned product words with a sticky overflow
// flag and a held result that waits for the consumer's out_ready.
`timescale 1ns/1ps
module acc_int3
   import acc_int3_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic       clk,
   input  logic       rst_n,
   acc_int3_if.slave  bus
);

   state_t               state;
   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH-1:0] p_ext;
   logic [ACC_WIDTH-1:0] add_sum;
   logic                 add_cout;
   logic                 ovf;
   logic [CNT_WIDTH-1:0] remaining;
   logic                 take;

   // Products are unsigned; widen into the accumulator width with zeros.
   always_comb begin
      p_ext            = '0;
      p_ext[WIDTH-1:0] = bus.P;
   end

   adder_nbit #(
      .N (ACC_WIDTH)
   ) u_adder (
      .a    (acc),
      .b    (p_ext),
      .s    (add_sum),
      .cout (add_cout)
   );

   assign take = (state == ACC) && bus.in_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc       <= '0;
         ovf       <= 1'b0;
         remaining <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  acc       <= '0;
                  ovf       <= 1'b0;
                  remaining <= bus.len;
                  state     <= (bus.len == '0) ? DONE : ACC;
               end
            end
            ACC: begin
               if (take) begin
                  acc       <= add_sum;
                  ovf       <= ovf | add_cout;
                  remaining <= remaining - CNT_WIDTH'(1);
                  if (remaining == CNT_WIDTH'(1)) state <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Handshake outputs decode the registered state only, never in_valid.
   assign bus.in_ready  = (state == ACC);
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state != IDLE);
   assign bus.sum       = acc;
   assign bus.ovf       = ovf;

endmodule

// File: tb/tb_acc_int3.sv
// Scoreboard bench for acc_int3: expected results are queued as products are
// driven and compared when the accumulator presents its result.
`timescale 1ns/1ps
module tb_acc_int3;
   import acc_int3_pkg::*;

   typedef struct {
      logic [7:0] sum;
      logic       ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;
   exp_t exp_q[$];
   int   m_acc;
   logic m_ovf;

   acc_int3_if #(.WIDTH(3), .ACC_WIDTH(8), .CNT_WIDTH(4)) ifa ();
   acc_int3_if #(.WIDTH(3), .ACC_WIDTH(4), .CNT_WIDTH(4)) ifb ();

   acc_int3 #(.WIDTH(3), .ACC_WIDTH(8), .CNT_WIDTH(4)) dut_a (
      .clk (clk), .rst_n (rst_n), .bus (ifa.slave)
   );
   acc_int3 #(.WIDTH(3), .ACC_WIDTH(4), .CNT_WIDTH(4)) dut_b (
      .clk (clk), .rst_n (rst_n), .bus (ifb.slave)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

   task automatic model_add(input int p, input int aw);
      m_acc = m_acc + p;
      if (m_acc >= (1 << aw)) m_ovf = 1'b1;
      m_acc = m_acc % (1 << aw);
   endtask

   task automatic start_a(input int n);
      ifa.start = 1'b1;
      ifa.len   = 4'(n);
      m_acc     = 0;
      m_ovf     = 1'b0;
      @(negedge clk);
      ifa.start = 1'b0;
   endtask

   task automatic push_p_a(input int p, input bit last);
      ifa.in_valid = 1'b1;
      ifa.P        = 3'(p);
      model_add(p, 8);
      if (last) exp_q.push_back('{8'(m_acc), m_ovf});
      @(negedge clk);
      ifa.in_valid = 1'b0;
   endtask

   task automatic idle_a();
      ifa.in_valid = 1'b0;
      ifa.P        = 3'd7;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ifa.start = 0; ifa.len = 0; ifa.P = 0; ifa.in_valid = 0; ifa.out_ready = 1;
      ifb.start = 0; ifb.len = 0; ifb.P = 0; ifb.in_valid = 0; ifb.out_ready = 1;
      repeat (3) @(negedge clk);
      checks++; if (ifa.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", ifa.in_ready); end
      checks++; if (ifa.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", ifa.out_valid); end
      checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", ifa.busy); end
      checks++; if (ifa.sum !== 8'd0) begin errors++; $display("FAIL rst_sum: got %0d want 0", ifa.sum); end
      checks++; if (ifa.ovf !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b want 0", ifa.ovf); end
      checks++; if (ifb.out_valid !== 1'b0 || ifb.sum !== 4'd0) begin
         errors++; $display("FAIL rst_b: out_valid=%b sum=%0d want 0/0", ifb.out_valid, ifb.sum);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      exp_t e;
      ifa.out_ready = 1'b1;
      start_a(3);
      checks++; if (ifa.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b want 1", ifa.busy); end
      checks++; if (ifa.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", ifa.in_ready); end
      push_p_a(5, 0);
      push_p_a(7, 0);
      push_p_a(2, 1);
      checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_latency: out_valid=%b want 1", ifa.out_valid); end
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_scoreboard: queue empty"); end
      else begin
         e = exp_q.pop_front();
         if (ifa.sum !== e.sum || ifa.ovf !== e.ovf) begin
            errors++; $display("FAIL b2b_result: sum=%0d ovf=%b want %0d/%b", ifa.sum, ifa.ovf, e.sum, e.ovf);
         end
      end
      @(negedge clk);
      checks++; if (ifa.out_valid !== 1'b0 || ifa.busy !== 1'b0) begin
         errors++; $display("FAIL b2b_idle: out_valid=%b busy=%b want 0/0", ifa.out_valid, ifa.busy);
      end
      checks++; if (ifa.sum !== 8'd14) begin errors++; $display("FAIL b2b_hold_idle: sum=%0d want 14", ifa.sum); end
   endtask

   task automatic test_wrap();
      exp_t e;
      ifb.out_ready = 1'b1;
      ifb.start     = 1'b1;
      ifb.len       = 4'd3;
      m_acc = 0; m_ovf = 1'b0;
      @(negedge clk);
      ifb.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ifb.in_valid = 1'b1;
         ifb.P        = 3'd7;
         model_add(7, 4);
         @(negedge clk);
      end
      ifb.in_valid = 1'b0;
      exp_q.push_back('{8'(m_acc), m_ovf});
      checks++; if (ifb.out_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid: out_valid=%b want 1", ifb.out_valid); end
      e = exp_q.pop_back();
      checks++; if (ifb.sum !== e.sum[3:0]) begin errors++; $display("FAIL wrap_sum: got %0d want %0d", ifb.sum, e.sum[3:0]); end
      checks++; if (ifb.ovf !== e.ovf) begin errors++; $display("FAIL wrap_ovf: got %b want %b", ifb.ovf, e.ovf); end
      @(negedge clk);
   endtask

   task automatic test_valid_gaps();
      exp_t e;
      start_a(2);
      push_p_a(3, 0);
      idle_a();
      checks++; if (ifa.in_ready !== 1'b1 || ifa.out_valid !== 1'b0) begin
         errors++; $display("FAIL gap_state: in_ready=%b out_valid=%b want 1/0", ifa.in_ready, ifa.out_valid);
      end
      idle_a();
      push_p_a(4, 1);
      checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL gap_valid: out_valid=%b want 1", ifa.out_valid); end
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL gap_scoreboard: queue empty"); end
      else begin
         e = exp_q.pop_front();
         if (ifa.sum !== e.sum || ifa.ovf !== e.ovf) begin
            errors++; $display("FAIL gap_result: sum=%0d ovf=%b want %0d/%b", ifa.sum, ifa.ovf, e.sum, e.ovf);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_hold();
      exp_t e;
      ifa.out_ready = 1'b0;
      start_a(1);
      push_p_a(6, 1);
      e = '{8'd0, 1'b0};
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL hold_scoreboard: queue empty"); end
      else e = exp_q.pop_front();
      for (int i = 0; i < 5; i++) begin
         checks++; if (ifa.out_valid !== 1'b1 || ifa.sum !== e.sum || ifa.ovf !== e.ovf) begin
            errors++; $display("FAIL hold_cycle%0d: out_valid=%b sum=%0d ovf=%b want 1/%0d/%b",
                                i, ifa.out_valid, ifa.sum, ifa.ovf, e.sum, e.ovf);
         end
         @(negedge clk);
      end
      ifa.out_ready = 1'b1;
      @(negedge clk);
      checks++; if (ifa.busy !== 1'b0 || ifa.out_valid !== 1'b0) begin
         errors++; $display("FAIL hold_release: busy=%b out_valid=%b want 0/0", ifa.busy, ifa.out_valid);
      end
   endtask

   task automatic test_len_zero();
      exp_t e;
      ifa.out_ready = 1'b0;
      start_a(0);
      exp_q.push_back('{8'd0, 1'b0});
      checks++; if (ifa.out_valid !== 1'b1 || ifa.in_ready !== 1'b0) begin
         errors++; $display("FAIL len0_state: out_valid=%b in_ready=%b want 1/0", ifa.out_valid, ifa.in_ready);
      end
      e = exp_q.pop_front();
      checks++; if (ifa.sum !== e.sum || ifa.ovf !== e.ovf) begin
         errors++; $display("FAIL len0_result: sum=%0d ovf=%b want %0d/%b", ifa.sum, ifa.ovf, e.sum, e.ovf);
      end
      ifa.out_ready = 1'b1;
      @(negedge clk);
      checks++; if (ifa.busy !== 1'b0) begin errors++; $display("FAIL len0_idle: busy=%b want 0", ifa.busy); end
      // start pulsed during ACC must neither reload len nor clear the sum
      start_a(2);
      push_p_a(1, 0);
      ifa.start = 1'b1;
      ifa.len   = 4'd5;
      push_p_a(2, 1);
      ifa.start = 1'b0;
      checks++; if (ifa.out_valid !== 1'b1) begin errors++; $display("FAIL start_in_acc_valid: out_valid=%b want 1", ifa.out_valid); end
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL start_in_acc_scoreboard: queue empty"); end
      else begin
         e = exp_q.pop_front();
         if (ifa.sum !== e.sum) begin errors++; $display("FAIL start_in_acc_sum: got %0d want %0d", ifa.sum, e.sum); end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_abort();
      exp_t e;
      bit   got;
      start_a(4);
      push_p_a(1, 0);
      push_p_a(2, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (ifa.busy !== 1'b0 || ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b0) begin
         errors++; $display("FAIL abort_state: busy=%b out_valid=%b in_ready=%b want 0/0/0", ifa.busy, ifa.out_valid, ifa.in_ready);
      end
      checks++; if (ifa.sum !== 8'd0 || ifa.ovf !== 1'b0) begin
         errors++; $display("FAIL abort_clear: sum=%0d ovf=%b want 0/0", ifa.sum, ifa.ovf);
      end
      start_a(1);
      push_p_a(3, 1);
      got = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (ifa.out_valid === 1'b1) begin got = 1'b1; break; end
         @(negedge clk);
      end
      checks++;
      if (!got) begin errors++; $display("FAIL abort_restart_timeout: out_valid=%b want 1 within 20 cycles", ifa.out_valid); end
      else if (exp_q.size() == 0) begin errors++; $display("FAIL abort_scoreboard: queue empty"); end
      else begin
         e = exp_q.pop_front();
         if (ifa.sum !== e.sum) begin errors++; $display("FAIL abort_restart_sum: got %0d want %0d", ifa.sum, e.sum); end
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_wrap();
      test_valid_gaps();
      test_hold();
      test_len_zero();
      test_reset_abort();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
